// File: rtl/spi_reg_bank_if.sv
// SPI slave <-> register bank handshake bundle.
// master: driven by the SPI slave side; slave: the register bank.
interface spi_reg_bank_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 24
);
  logic [ADDR_W-1:0] spi_addr;
  logic              spi_addr_rdy;
  logic              spi_rw;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_data_rdy;
  logic [DATA_W-1:0] spi_rdata;

  modport master (
    output spi_addr, spi_addr_rdy, spi_rw, spi_wdata, spi_data_rdy,
    input  spi_rdata
  );

  modport slave (
    input  spi_addr, spi_addr_rdy, spi_rw, spi_wdata, spi_data_rdy,
    output spi_rdata
  );
endinterface

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave: strobe synchronisation, address decode,
// R/W control registers, status/ID/error-count readback, self-clearing CMD
// register and stretched soft reset.
// Optional macro SPI_REG_WRLOCK_EN adds a write-lock register at all-ones-2.
module spi_reg_bank #(
  parameter int unsigned       ADDR_W      = 7,
  parameter int unsigned       DATA_W      = 24,
  parameter int unsigned       NUM_REGS    = 8,
  parameter logic [DATA_W-1:0] DEVICE_ID   = 24'hF0CCAB,
  parameter logic [DATA_W-1:0] REG_RST_VAL = '0,
  parameter int unsigned       RST_CYCLES  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_reg_bank_if.slave              bus,
  input  logic [DATA_W-1:0]          status_in,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic [DATA_W-1:0]          cmd_pulse,
  output logic                       soft_rst
);

  localparam logic [ADDR_W-1:0] A_CMD    = '0;
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_ID     = '1;
  localparam logic [ADDR_W-1:0] A_ERR    = A_ID - ADDR_W'(1);
`ifdef SPI_REG_WRLOCK_EN
  localparam logic [ADDR_W-1:0] A_LOCK   = A_ID - ADDR_W'(2);
`endif
  localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);

  logic [1:0]        a_sync_q, d_sync_q;
  logic              a_prev_q, d_prev_q;
  logic              a_edge_q, d_edge_q;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic [7:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              soft_rst_q;
  logic              wr_locked;
`ifdef SPI_REG_WRLOCK_EN
  logic              lock_q, lock_d;
  assign wr_locked = lock_q;
`else
  assign wr_locked = 1'b0;
`endif

  logic [31:0] addr_u;
  logic        hit_cmd, hit_stat, hit_err, hit_id, hit_rw, hit_lock;
  logic        blocked, err_inc;

  assign addr_u   = 32'(bus.spi_addr);
  assign hit_cmd  = (bus.spi_addr == A_CMD);
  assign hit_stat = (bus.spi_addr == A_STATUS);
  assign hit_err  = (bus.spi_addr == A_ERR);
  assign hit_id   = (bus.spi_addr == A_ID);
  assign hit_rw   = (addr_u >= 32'd2) && (addr_u < NUM_REGS + 2);
`ifdef SPI_REG_WRLOCK_EN
  assign hit_lock = (bus.spi_addr == A_LOCK);
`else
  assign hit_lock = 1'b0;
`endif

  // Soft reset covers the cycle the counter is loaded through the last high cycle.
  assign blocked = (cnt_q != '0) | soft_rst_q;

  // Two-flop synchronisers plus registered rising-edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= '0;
      d_sync_q <= '0;
      a_prev_q <= 1'b0;
      d_prev_q <= 1'b0;
      a_edge_q <= 1'b0;
      d_edge_q <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[0], bus.spi_addr_rdy};
      d_sync_q <= {d_sync_q[0], bus.spi_data_rdy};
      a_prev_q <= a_sync_q[1];
      d_prev_q <= d_sync_q[1];
      a_edge_q <= a_sync_q[1] & ~a_prev_q;
      d_edge_q <= d_sync_q[1] & ~d_prev_q;
    end
  end

  // Decode, read mux, write/strobe/error/soft-reset next-state logic.
  always_comb begin
    regs_d   = regs_q;
    rdata_d  = rdata_q;
    wr_stb_d = '0;
    cmd_d    = '0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    err_inc  = 1'b0;
`ifdef SPI_REG_WRLOCK_EN
    lock_d   = lock_q;
`endif
    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);

    if (a_edge_q) begin
      if (hit_cmd)       rdata_d = '0;
      else if (hit_stat) rdata_d = status_in;
      else if (hit_rw) begin
        for (int unsigned k = 0; k < NUM_REGS; k++)
          if (addr_u == k + 2) rdata_d = regs_q[k];
      end
      else if (hit_err)  rdata_d = DATA_W'(err_q);
      else if (hit_id)   rdata_d = DEVICE_ID;
`ifdef SPI_REG_WRLOCK_EN
      else if (hit_lock) rdata_d = DATA_W'(lock_q);
`endif
      else begin
        rdata_d = '0;
        err_inc = 1'b1;
      end
    end

    if (d_edge_q && !bus.spi_rw) begin
      // CMD stays live during soft reset so bit0 can restart the count.
      if (hit_cmd) begin
        cmd_d = bus.spi_wdata;
        if (bus.spi_wdata[0]) cnt_d = CNT_W'(RST_CYCLES);
      end else if (hit_rw) begin
        if (wr_locked) err_inc = 1'b1;
        else begin
          for (int unsigned k = 0; k < NUM_REGS; k++)
            if (addr_u == k + 2) begin
              regs_d[k]   = bus.spi_wdata;
              wr_stb_d[k] = 1'b1;
            end
        end
      end else if (hit_stat || hit_err || hit_id) begin
        err_inc = 1'b1;
      end
`ifdef SPI_REG_WRLOCK_EN
      else if (hit_lock && !blocked) begin
        lock_d = (bus.spi_wdata[7:0] != 8'hA5);
      end
`endif
    end

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;

    if (blocked) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_d[k] = REG_RST_VAL;
      wr_stb_d = '0;
      err_d    = '0;
    end
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= REG_RST_VAL;
      rdata_q    <= '0;
      wr_stb_q   <= '0;
      cmd_q      <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      soft_rst_q <= 1'b0;
`ifdef SPI_REG_WRLOCK_EN
      lock_q     <= 1'b1;
`endif
    end else begin
      regs_q     <= regs_d;
      rdata_q    <= rdata_d;
      wr_stb_q   <= wr_stb_d;
      cmd_q      <= cmd_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      soft_rst_q <= (cnt_q != '0);
`ifdef SPI_REG_WRLOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  // Flatten the register array onto the output bus.
  always_comb begin
    regs_flat = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++)
      regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign bus.spi_rdata = rdata_q;
  assign wr_stb        = wr_stb_q;
  assign cmd_pulse     = cmd_q;
  assign soft_rst      = soft_rst_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank (default parameters).
module tb_spi_reg_bank;
  logic clk = 1'b0;
  logic rst;
  logic [23:0]  status_in;
  logic [191:0] regs_flat;
  logic [7:0]   wr_stb;
  logic [23:0]  cmd_pulse;
  logic         soft_rst;

  int checks   = 0;
  int failures = 0;

  // Snapshots taken by xfer
  logic [23:0]  x_rd3, x_rd4, x_cmd, x_cmd1;
  logic [7:0]   x_stb, x_stb1;
  logic [191:0] x_regs;
  int           x_srst;
  logic [23:0]  rd;

`ifdef SPI_REG_WRLOCK_EN
  localparam logic [7:0] ERR_BASE = 8'd1;
`else
  localparam logic [7:0] ERR_BASE = 8'd0;
`endif

  always #5 clk = ~clk;

  spi_reg_bank_if #(.ADDR_W(7), .DATA_W(24)) bus ();

  spi_reg_bank #(
    .ADDR_W(7), .DATA_W(24), .NUM_REGS(8), .DEVICE_ID(24'hF0CCAB),
    .REG_RST_VAL(24'h0), .RST_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .status_in(status_in),
    .regs_flat(regs_flat), .wr_stb(wr_stb), .cmd_pulse(cmd_pulse), .soft_rst(soft_rst)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic count_srst();
    if (soft_rst === 1'b1) x_srst++;
  endtask

  // One transaction: strobes high for two edges, action lands on the 4th edge.
  task automatic xfer(input logic [6:0] a, input logic rw, input logic [23:0] wd, input logic with_data);
    @(negedge clk);
    bus.spi_addr = a; bus.spi_rw = rw; bus.spi_wdata = wd;
    bus.spi_addr_rdy = 1'b1; bus.spi_data_rdy = with_data;
    x_srst = 0;
    @(posedge clk); #1; x_cmd1 = cmd_pulse; x_stb1 = wr_stb; count_srst();
    @(posedge clk); #1; count_srst();
    @(negedge clk);
    bus.spi_addr_rdy = 1'b0; bus.spi_data_rdy = 1'b0;
    @(posedge clk); #1; x_rd3 = bus.spi_rdata; count_srst();
    @(posedge clk); #1; x_rd4 = bus.spi_rdata; x_stb = wr_stb; x_cmd = cmd_pulse;
    x_regs = regs_flat; count_srst();
  endtask

  task automatic rd_reg(input logic [6:0] a, output logic [23:0] d);
    xfer(a, 1'b1, 24'h0, 1'b0);
    d = x_rd4;
  endtask

  initial begin
    rst = 1'b1; status_in = 24'h0;
    bus.spi_addr = '0; bus.spi_rw = 1'b0; bus.spi_wdata = '0;
    bus.spi_addr_rdy = 1'b0; bus.spi_data_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_rdata", bus.spi_rdata, 0);
    check("rst_regs", regs_flat, 0);
    check("rst_wrstb", wr_stb, 0);
    check("rst_cmd", cmd_pulse, 0);
    check("rst_softrst", soft_rst, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    // Device ID: not yet loaded after 3 edges, loaded on the 4th
    xfer(7'd127, 1'b1, 24'h0, 1'b0);
    check("id_lat3", x_rd3, 0);
    check("id_lat4", x_rd4, 24'hF0CCAB);

`ifdef SPI_REG_WRLOCK_EN
    xfer(7'd2, 1'b0, 24'h111111, 1'b1);
    check("lock_drop_stb", x_stb, 0);
    check("lock_drop_reg0", x_regs[23:0], 0);
    rd_reg(7'd126, rd); check("lock_err1", rd, 1);
    rd_reg(7'd125, rd); check("lock_rd_locked", rd, 1);
    xfer(7'd125, 1'b0, 24'h0000A5, 1'b1);
    rd_reg(7'd125, rd); check("lock_rd_unlocked", rd, 0);
    xfer(7'd2, 1'b0, 24'hABCDEF, 1'b1);
    check("lock_wr_reg0", x_regs[23:0], 24'hABCDEF);
    check("lock_wr_stb", x_stb, 8'b0000_0001);
`endif

    // Write reg 1 (address 3)
    xfer(7'd3, 1'b0, 24'h123456, 1'b1);
    check("wr3_reg1", x_regs[47:24], 24'h123456);
    check("wr3_stb", x_stb, 8'b0000_0010);
    check("wr3_cmd_quiet", x_cmd, 0);
    @(posedge clk); #1;
    check("wr3_stb_1cyc", wr_stb, 0);
    rd_reg(7'd3, rd); check("rd3", rd, 24'h123456);

    // Write reg 0, then an rw=1 data strobe must leave it alone
    xfer(7'd2, 1'b0, 24'h00AAAA, 1'b1);
    check("wr2_reg0", x_regs[23:0], 24'h00AAAA);
    xfer(7'd2, 1'b1, 24'h555555, 1'b1);
    check("rw1_stb", x_stb, 0);
    check("rw1_reg0", x_regs[23:0], 24'h00AAAA);
    rd_reg(7'd126, rd); check("rw1_err", rd, 24'(ERR_BASE));

    // Status sampled live, CMD reads as zero
    status_in = 24'h5A5A5A;
    rd_reg(7'd1, rd); check("rd_status", rd, 24'h5A5A5A);
    rd_reg(7'd0, rd); check("rd_cmd_zero", rd, 0);

    // Soft reset via CMD bit0; following write lands inside the reset window
    xfer(7'd0, 1'b0, 24'h000005, 1'b1);
    check("cmd_pulse", x_cmd, 24'h000005);
    check("cmd_no_srst_yet", x_srst, 0);
    xfer(7'd2, 1'b0, 24'h000777, 1'b1);
    check("cmd_pulse_1cyc", x_cmd1, 0);
    check("srst_len", x_srst, 4);
    check("srst_drop_stb", x_stb, 0);
    check("srst_regs_clr", x_regs, 0);
    @(posedge clk); #1;
    check("srst_end", soft_rst, 0);
    rd_reg(7'd2, rd); check("srst_rd_reg0", rd, 0);
    rd_reg(7'd126, rd); check("srst_err_clr", rd, 0);

    // Unmapped reads count errors, saturating at 255
    for (int i = 0; i < 3; i++) rd_reg(7'd50, rd);
    check("unmapped_rd0", rd, 0);
    rd_reg(7'd126, rd); check("err_3", rd, 3);
    for (int i = 0; i < 297; i++) rd_reg(7'd50, rd);
    rd_reg(7'd126, rd); check("err_sat", rd, 255);
    xfer(7'd1, 1'b0, 24'h0F0F0F, 1'b1);
    rd_reg(7'd126, rd); check("err_sat_hold", rd, 255);
    rd_reg(7'd1, rd); check("status_ro", rd, 24'h5A5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
